regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a pending-write scoreboard and a sequential post-reset clear sequencer. It sits in the decode/writeback stage of the RV32 core. It serves NRD combinational read ports and two writeback ports: port 0 for ALU/CSR results, port 1 for load/M-unit results. It also tracks which architectural registers still have a result in flight.

---
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two writeback ports, packed read ports, issue/flush
// scoreboard controls and the ready indication.
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
);
   logic                ready;
   logic                we0;
   logic [AW-1:0]       wa0;
   logic [XLEN-1:0]     wd0;
   logic                we1;
   logic [AW-1:0]       wa1;
   logic [XLEN-1:0]     wd1;
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic [NRD-1:0]      rbusy;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                flush;

   modport master (
      input  ready, rd, rbusy,
      output we0, wa0, wd0, we1, wa1, wd1, ra, iss_valid, iss_rd, flush
   );

   modport slave (
      output ready, rd, rbusy,
      input  we0, wa0, wd0, we1, wa1, wd1, ra, iss_valid, iss_rd, flush
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and post-reset clear.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
) (
   input  logic          clk,
   input  logic          rst,
   regfile_mp_if.slave   bus
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state, state_next;
   logic [AW-1:0]       clr_idx;
   logic                clr_last;
   logic [XLEN-1:0]     mem [NREG];
   logic [NREG-1:0]     sb, sb_next;
   logic [NRD*XLEN-1:0] rd_n;
   logic [NRD-1:0]      rbusy_n;
   logic [AW-1:0]       addr;

   assign clr_last  = (clr_idx == AW'(NREG - 1));
   assign bus.ready = (state == RUN);
   assign bus.rd    = rd_n;
   assign bus.rbusy = rbusy_n;

   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR: if (clr_last) state_next = RUN;
         RUN:   state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                 clr_idx <= '0;
      else if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
   end

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_idx] <= '0;
         end else begin
            if (bus.we0 && bus.wa0 != '0) mem[bus.wa0] <= bus.wd0;
            if (bus.we1 && bus.wa1 != '0) mem[bus.wa1] <= bus.wd1;
         end
      end
   end

   // Issue set is applied after write clears so a new producer stays outstanding.
   always_comb begin
      sb_next = sb;
      if (bus.flush) begin
         sb_next = '0;
      end else begin
         if (bus.we0) sb_next[bus.wa0] = 1'b0;
         if (bus.we1) sb_next[bus.wa1] = 1'b0;
         if (bus.iss_valid && bus.iss_rd != '0) sb_next[bus.iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)               sb <= '0;
      else if (state == RUN) sb <= sb_next;
   end

   always_comb begin
      rd_n    = '0;
      rbusy_n = '0;
      addr    = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         addr = bus.ra[k*AW +: AW];
         if (state == RUN && addr != '0) begin
            rd_n[k*XLEN +: XLEN] = mem[addr];
            rbusy_n[k]           = sb[addr];
`ifdef REGFILE_BYPASS_EN
            if (bus.we1 && bus.wa1 == addr) begin
               rd_n[k*XLEN +: XLEN] = bus.wd1;
               rbusy_n[k]           = 1'b0;
            end else if (bus.we0 && bus.wa0 == addr) begin
               rd_n[k*XLEN +: XLEN] = bus.wd0;
               rbusy_n[k]           = 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default 32x32/2-port instance and a
// 16x64/4-port instance share clock and reset.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int K_RDA = 0, K_BSA = 1, K_RDYA = 2, K_RDB = 3, K_RDYB = 4,
                  K_BSB = 5, K_CLA = 6, K_CLB = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) bus_a ();
   regfile_mp_if #(.XLEN(64), .AW(4), .NRD(4)) bus_b ();

   regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave));
   regfile_mp #(.XLEN(64), .NREG(16), .AW(4), .NRD(4)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave));

   typedef struct {
      string       tag;
      int          kind;
      int          port;
      logic [63:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cnt_a, cnt_b;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int kind, input int port);
      case (kind)
         K_RDA:  return 64'(bus_a.rd[port*32 +: 32]);
         K_BSA:  return 64'(bus_a.rbusy[port]);
         K_RDYA: return 64'(bus_a.ready);
         K_RDB:  return bus_b.rd[port*64 +: 64];
         K_RDYB: return 64'(bus_b.ready);
         K_BSB:  return 64'(bus_b.rbusy[port]);
         K_CLA:  return 64'(cnt_a);
         K_CLB:  return 64'(cnt_b);
         default: return 'x;
      endcase
   endfunction

   task automatic push(input string tag, input int kind, input int port, input logic [63:0] exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.port = port;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check(e.tag, observe(e.kind, e.port), e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_a.we0 = 1'b0; bus_a.wa0 = '0; bus_a.wd0 = '0;
      bus_a.we1 = 1'b0; bus_a.wa1 = '0; bus_a.wd1 = '0;
      bus_a.iss_valid = 1'b0; bus_a.iss_rd = '0; bus_a.flush = 1'b0;
      bus_b.we0 = 1'b0; bus_b.wa0 = '0; bus_b.wd0 = '0;
      bus_b.we1 = 1'b0; bus_b.wa1 = '0; bus_b.wd1 = '0;
      bus_b.iss_valid = 1'b0; bus_b.iss_rd = '0; bus_b.flush = 1'b0;
   endtask

   // Called in cycle 1 after the reset edge; counts cycles with ready low.
   task automatic wait_ready();
      bit seen_a, seen_b;
      cnt_a = 0; cnt_b = 0; seen_a = 0; seen_b = 0;
      for (int c = 0; c < 100 && !(seen_a && seen_b); c++) begin
         bus_a.ra = {5'(c), 5'(31 - c)};
         bus_b.ra = {4'(c), 4'(c + 1), 4'(c + 2), 4'(c + 3)};
         #2;
         if (!seen_a) begin
            if (bus_a.ready) seen_a = 1; else cnt_a++;
         end
         if (!seen_b) begin
            if (bus_b.ready) seen_b = 1; else cnt_b++;
         end
         push("clr_rd0", K_RDA, 0, '0);
         push("clr_rd1", K_RDA, 1, '0);
         push("clr_busy0", K_BSA, 0, '0);
         push("clr_busy1", K_BSA, 1, '0);
         push("clr_rd_b3", K_RDB, 3, '0);
         drain();
         step();
      end
      push("clr_len_a", K_CLA, 0, 64'd32);
      push("clr_len_b", K_CLB, 0, 64'd16);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      idle();
      bus_a.ra = '0;
      bus_b.ra = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_ready();

      // All entries read zero after the clear sequence
      for (int r = 0; r < 32; r++) begin
         bus_a.ra = {5'(31 - r), 5'(r)};
         if (r < 16) bus_b.ra = {4'(r), 4'(r), 4'(r), 4'(r)};
         #1;
         push("post_clr_rd0", K_RDA, 0, '0);
         push("post_clr_rd1", K_RDA, 1, '0);
         push("post_clr_busy0", K_BSA, 0, '0);
         push("post_clr_rd_b", K_RDB, 0, '0);
         push("post_clr_busy_b", K_BSB, 2, '0);
         drain();
      end
      step();

      // Dual write collision on x5
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd5; bus_a.wd0 = 32'h1111_1111;
      bus_a.we1 = 1'b1; bus_a.wa1 = 5'd5; bus_a.wd1 = 32'h2222_2222;
      bus_a.ra = {5'd0, 5'd5};
      #2;
      push("coll_same_cycle", K_RDA, 0, BYP ? 64'h2222_2222 : 64'h0);
      drain();
      step(); idle(); #2;
      push("coll_p1_wins", K_RDA, 0, 64'h2222_2222);
      push("x0_read", K_RDA, 1, '0);
      drain();

      // Writes to x0 are dropped
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd0; bus_a.wd0 = 32'hDEAD_BEEF;
      bus_a.we1 = 1'b1; bus_a.wa1 = 5'd0; bus_a.wd1 = 32'hDEAD_BEEF;
      bus_a.ra = {5'd0, 5'd0};
      #2;
      push("x0_same_cycle", K_RDA, 0, '0);
      drain();
      step(); idle(); #2;
      push("x0_after_p0", K_RDA, 0, '0);
      push("x0_after_p1", K_RDA, 1, '0);
      drain();

      // Scoreboard set / clear / collision / flush
      bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd7;
      bus_a.ra = {5'd7, 5'd0};
      #2;
      push("sb_not_yet", K_BSA, 1, 64'd0);
      drain();
      step(); idle(); #2;
      push("sb_set_x7", K_BSA, 1, 64'd1);
      drain();
      bus_a.we1 = 1'b1; bus_a.wa1 = 5'd7; bus_a.wd1 = 32'h0000_0077;
      #2;
      push("sb_wr_same_cycle", K_BSA, 1, BYP ? 64'd0 : 64'd1);
      drain();
      step(); idle(); #2;
      push("sb_clr_x7", K_BSA, 1, 64'd0);
      push("wr_x7", K_RDA, 1, 64'h77);
      drain();
      bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd7;
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd7; bus_a.wd0 = 32'h0000_0078;
      step(); idle(); #2;
      push("sb_iss_wins", K_BSA, 1, 64'd1);
      push("wr_x7_b", K_RDA, 1, 64'h78);
      drain();
      bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd10;
      step(); idle();
      bus_a.flush = 1'b1; bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd9;
      step(); idle();
      bus_a.ra = {5'd7, 5'd9};
      #2;
      push("flush_x9", K_BSA, 0, 64'd0);
      push("flush_x7", K_BSA, 1, 64'd0);
      drain();
      bus_a.ra = {5'd10, 5'd9};
      #1;
      push("flush_x10", K_BSA, 1, 64'd0);
      drain();
      step();

      // Same-cycle read of a write in flight
      bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd3;
      step(); idle();
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd3; bus_a.wd0 = 32'hCAFE_0001;
      bus_a.ra = {5'd0, 5'd3};
      #2;
      push("byp_rd", K_RDA, 0, BYP ? 64'hCAFE_0001 : 64'h0);
      push("byp_busy", K_BSA, 0, BYP ? 64'd0 : 64'd1);
      drain();
      step(); idle(); #2;
      push("after_byp_rd", K_RDA, 0, 64'hCAFE_0001);
      push("after_byp_busy", K_BSA, 0, 64'd0);
      drain();

      // Reset mid-run
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd4; bus_a.wd0 = 32'h55;
      bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd6;
      step(); idle();
      bus_a.ra = {5'd6, 5'd4};
      #2;
      push("pre_rst_x4", K_RDA, 0, 64'h55);
      push("pre_rst_busy6", K_BSA, 1, 64'd1);
      drain();
      step();
      rst = 1'b1;
      bus_a.we0 = 1'b1; bus_a.wa0 = 5'd8; bus_a.wd0 = 32'h99;
      step();
      rst = 1'b0;
      idle();
      #2;
      push("rst_ready_a", K_RDYA, 0, 64'd0);
      push("rst_ready_b", K_RDYB, 0, 64'd0);
      push("rst_busy6", K_BSA, 1, 64'd0);
      drain();
      #1;
      wait_ready();
      bus_a.ra = {5'd8, 5'd4};
      #2;
      push("rst_x4_cleared", K_RDA, 0, '0);
      push("rst_x8_lost", K_RDA, 1, '0);
      drain();
      bus_a.ra = {5'd6, 5'd6};
      #1;
      push("rst_busy6_after", K_BSA, 0, 64'd0);
      drain();
      step();

      // Wide/4-port instance: distinct values on every read port
      bus_b.we0 = 1'b1; bus_b.wa0 = 4'd1;  bus_b.wd0 = 64'h0123_4567_89AB_CDEF;
      bus_b.we1 = 1'b1; bus_b.wa1 = 4'd15; bus_b.wd1 = 64'hFEDC_BA98_7654_3210;
      step();
      bus_b.we0 = 1'b1; bus_b.wa0 = 4'd8;  bus_b.wd0 = 64'hA5A5_0000_FFFF_5A5A;
      bus_b.we1 = 1'b1; bus_b.wa1 = 4'd2;  bus_b.wd1 = 64'h0000_0001_0000_0002;
      bus_b.iss_valid = 1'b1; bus_b.iss_rd = 4'd15;
      step(); idle();
      bus_b.ra = {4'd2, 4'd8, 4'd15, 4'd1};
      #2;
      push("b_p0_x1", K_RDB, 0, 64'h0123_4567_89AB_CDEF);
      push("b_p1_x15", K_RDB, 1, 64'hFEDC_BA98_7654_3210);
      push("b_p2_x8", K_RDB, 2, 64'hA5A5_0000_FFFF_5A5A);
      push("b_p3_x2", K_RDB, 3, 64'h0000_0001_0000_0002);
      push("b_busy_x15", K_BSB, 1, 64'd1);
      push("b_busy_x1", K_BSB, 0, 64'd0);
      drain();
      bus_b.ra = {4'd1, 4'd15, 4'd8, 4'd0};
      #1;
      push("b_p0_x0", K_RDB, 0, '0);
      push("b_p1_x8", K_RDB, 1, 64'hA5A5_0000_FFFF_5A5A);
      push("b_p2_x15", K_RDB, 2, 64'hFEDC_BA98_7654_3210);
      push("b_p3_x1", K_RDB, 3, 64'h0123_4567_89AB_CDEF);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
